// File: rtl/rv32i_mc_control_pkg.sv
// rtl/rv32i_mc_control_pkg.sv - rv32i encodings, datapath select enums and FSM states
package rv32i_mc_control_pkg;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND
  } arith_funct3_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SLL, ALU_SUB, ALU_SRA, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND
  } alu_ops_t;

  typedef enum logic [2:0] {
    LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000, SH = 3'b001, SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {PCMUX_PC4, PCMUX_ALU, PCMUX_TRAP} pcmux_sel_t;

  typedef enum logic [2:0] {
    AM2_I_IMM, AM2_U_IMM, AM2_B_IMM, AM2_S_IMM, AM2_J_IMM, AM2_RS2
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    RFM_ALU, RFM_BR_EN, RFM_U_IMM, RFM_LW, RFM_PC4, RFM_LH, RFM_LHU, RFM_LB, RFM_LBU
  } regfilemux_sel_t;

  typedef enum logic [1:0] {
    TC_ILLEGAL, TC_MISALIGNED_LD, TC_MISALIGNED_ST, TC_MEM_TIMEOUT
  } trap_cause_t;

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_IMM, S_REG, S_BR, S_JAL, S_JALR,
    S_LUI, S_AUIPC, S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2, S_TRAP
  } state_t;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // funct3[1] marks word access (needs 00), funct3[0] halfword (needs bit0 = 0)
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (f3[1] & (|lo)) | (f3[0] & lo[0]);
  endfunction

endpackage

// File: rtl/rv32i_mc_control_mem_wait_timer.sv
// rtl/rv32i_mc_control_mem_wait_timer.sv - memory-wait cycle counter with timeout expiry
module rv32i_mc_control_mem_wait_timer #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_mem_resp,
  output logic o_expire
);

  localparam bit                   LP_EN    = (MEM_TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TIMEOUT_W-1:0] r_count;

  // Held at zero outside wait states, so every wait state starts counting from 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (!i_active) begin
      r_count <= '0;
    end else if (!i_mem_resp) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign o_expire = LP_EN && i_active && !i_mem_resp && (r_count == LP_LIMIT);

endmodule

// File: rtl/rv32i_mc_control.sv
// rtl/rv32i_mc_control.sv - multicycle RV32I control FSM with traps and store lane steering
// Optional RV32I_CTRL_PERF_EN adds retire pulse and stall cycle counter ports.
module rv32i_mc_control
  import rv32i_mc_control_pkg::*;
#(
  parameter int TIMEOUT_W       = 8,
  parameter int MEM_TIMEOUT     = 255,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic        i_br_en,
  input  logic [1:0]  i_alu_addr_lo,
  input  logic        i_mem_resp,
  output logic        o_load_pc,
  output logic        o_load_ir,
  output logic        o_load_regfile,
  output logic        o_load_mar,
  output logic        o_load_mdr,
  output logic        o_load_data_out,
  output logic [1:0]  o_pcmux_sel,
  output logic        o_alumux1_sel,
  output logic [2:0]  o_alumux2_sel,
  output logic [3:0]  o_regfilemux_sel,
  output logic        o_marmux_sel,
  output logic        o_cmpmux_sel,
  output logic        o_jalr,
  output logic [2:0]  o_cmpop,
  output logic [2:0]  o_aluop,
  output logic [1:0]  o_byte_off,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [3:0]  o_mem_byte_enable,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
`ifdef RV32I_CTRL_PERF_EN
  ,
  output logic        o_retire,
  output logic [31:0] o_stall_cycles
`endif
);

  state_t          r_state;
  logic [1:0]      r_byte_off;
  trap_cause_t     r_trap_cause;
  logic            w_waiting, w_expire, w_misaligned, w_is_store;
  logic            w_load_pc, w_load_ir, w_load_regfile, w_load_mar, w_load_mdr, w_load_data_out;
  logic            w_mem_read, w_mem_write, w_trap, w_alumux1, w_marmux, w_cmpmux, w_jalr;
  pcmux_sel_t      w_pcmux;
  alumux2_sel_t    w_alumux2;
  regfilemux_sel_t w_regfilemux;
  logic [2:0]      w_cmpop, w_aluop;
  logic [3:0]      w_mbe;

  assign w_waiting    = (r_state == S_FETCH2) || (r_state == S_LDR1) || (r_state == S_STR1);
  assign w_is_store   = (i_opcode == OP_STORE);
  assign w_misaligned = is_misaligned(i_funct3, i_alu_addr_lo);

  rv32i_mc_control_mem_wait_timer #(
    .TIMEOUT_W   (TIMEOUT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_active   (w_waiting),
    .i_mem_resp (i_mem_resp),
    .o_expire   (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_FETCH1;
      r_byte_off   <= 2'b00;
      r_trap_cause <= TC_ILLEGAL;
    end else begin
      case (r_state)
        S_FETCH1: r_state <= S_FETCH2;
        S_FETCH2, S_LDR1, S_STR1: begin
          if (i_mem_resp) begin
            r_state <= (r_state == S_FETCH2) ? S_FETCH3 : (r_state == S_LDR1) ? S_LDR2 : S_STR2;
          end else if (w_expire) begin
            r_state      <= S_TRAP;
            r_trap_cause <= TC_MEM_TIMEOUT;
          end
        end
        S_FETCH3: r_state <= S_DECODE;
        S_DECODE: begin
          case (i_opcode)
            OP_IMM:             r_state <= S_IMM;
            OP_REG:             r_state <= S_REG;
            OP_BR:              r_state <= S_BR;
            OP_JAL:             r_state <= S_JAL;
            OP_JALR:            r_state <= S_JALR;
            OP_LUI:             r_state <= S_LUI;
            OP_AUIPC:           r_state <= S_AUIPC;
            OP_LOAD, OP_STORE:  r_state <= S_CALC_ADDR;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                r_state      <= S_TRAP;
                r_trap_cause <= TC_ILLEGAL;
              end else begin
                // STR2 is exactly "load_pc with PC+4", which is the NOP retire path
                r_state <= S_STR2;
              end
            end
          endcase
        end
        S_CALC_ADDR: begin
          if (w_misaligned) begin
            r_state      <= S_TRAP;
            r_trap_cause <= w_is_store ? TC_MISALIGNED_ST : TC_MISALIGNED_LD;
          end else begin
            r_byte_off <= i_alu_addr_lo;
            r_state    <= w_is_store ? S_STR1 : S_LDR1;
          end
        end
        default: r_state <= S_FETCH1;
      endcase
    end
  end

  always_comb begin
    w_load_pc       = 1'b0;
    w_load_ir       = 1'b0;
    w_load_regfile  = 1'b0;
    w_load_mar      = 1'b0;
    w_load_mdr      = 1'b0;
    w_load_data_out = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_trap          = 1'b0;
    w_pcmux         = PCMUX_PC4;
    w_alumux1       = 1'b0;
    w_alumux2       = AM2_I_IMM;
    w_regfilemux    = RFM_ALU;
    w_marmux        = 1'b0;
    w_cmpmux        = 1'b0;
    w_jalr          = 1'b0;
    w_cmpop         = i_funct3;
    w_aluop         = i_funct3;
    w_mbe           = 4'b1111;
    case (r_state)
      S_FETCH1: w_load_mar = 1'b1;
      S_FETCH2: begin w_mem_read = 1'b1; w_load_mdr = 1'b1; end
      S_FETCH3: w_load_ir = 1'b1;
      S_IMM, S_REG: begin
        w_load_regfile = 1'b1;
        w_load_pc      = 1'b1;
        if (r_state == S_REG) w_alumux2 = AM2_RS2;
        if (i_funct3 == F3_SLT || i_funct3 == F3_SLTU) begin
          w_cmpmux     = (r_state == S_IMM);
          w_regfilemux = RFM_BR_EN;
          w_cmpop      = (i_funct3 == F3_SLT) ? BLT : BLTU;
        end else if (i_funct3 == F3_SR && i_funct7 == FUNCT7_ALT) begin
          w_aluop = ALU_SRA;
        end else if (r_state == S_REG && i_funct3 == F3_ADD && i_funct7 == FUNCT7_ALT) begin
          w_aluop = ALU_SUB;
        end
      end
      S_BR: begin
        w_load_pc = 1'b1;
        w_alumux1 = 1'b1;
        w_alumux2 = AM2_B_IMM;
        w_aluop   = ALU_ADD;
        w_pcmux   = i_br_en ? PCMUX_ALU : PCMUX_PC4;
      end
      S_JAL, S_JALR: begin
        w_load_pc      = 1'b1;
        w_load_regfile = 1'b1;
        w_regfilemux   = RFM_PC4;
        w_pcmux        = PCMUX_ALU;
        w_aluop        = ALU_ADD;
        w_alumux1      = (r_state == S_JAL);
        w_alumux2      = (r_state == S_JAL) ? AM2_J_IMM : AM2_I_IMM;
        w_jalr         = (r_state == S_JALR);
      end
      S_LUI: begin w_load_pc = 1'b1; w_load_regfile = 1'b1; w_regfilemux = RFM_U_IMM; end
      S_AUIPC: begin
        w_load_pc      = 1'b1;
        w_load_regfile = 1'b1;
        w_alumux1      = 1'b1;
        w_alumux2      = AM2_U_IMM;
        w_aluop        = ALU_ADD;
      end
      S_CALC_ADDR: begin
        w_aluop         = ALU_ADD;
        w_marmux        = 1'b1;
        w_alumux2       = w_is_store ? AM2_S_IMM : AM2_I_IMM;
        w_load_mar      = !w_misaligned;
        w_load_data_out = w_is_store && !w_misaligned;
      end
      S_LDR1: begin w_mem_read = 1'b1; w_load_mdr = 1'b1; end
      S_LDR2: begin
        w_load_regfile = 1'b1;
        w_load_pc      = 1'b1;
        case (i_funct3)
          LB:      w_regfilemux = RFM_LB;
          LH:      w_regfilemux = RFM_LH;
          LBU:     w_regfilemux = RFM_LBU;
          LHU:     w_regfilemux = RFM_LHU;
          default: w_regfilemux = RFM_LW;
        endcase
      end
      S_STR1: begin
        w_mem_write = 1'b1;
        case (i_funct3)
          SB:      w_mbe = 4'b0001 << r_byte_off;
          SH:      w_mbe = 4'b0011 << r_byte_off;
          default: w_mbe = 4'b1111;
        endcase
      end
      S_STR2: w_load_pc = 1'b1;
      S_TRAP: begin w_trap = 1'b1; w_load_pc = 1'b1; w_pcmux = PCMUX_TRAP; end
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so an in-flight access drops the instant reset asserts
  assign o_load_pc         = w_load_pc & i_rst_n;
  assign o_load_ir         = w_load_ir & i_rst_n;
  assign o_load_regfile    = w_load_regfile & i_rst_n;
  assign o_load_mar        = w_load_mar & i_rst_n;
  assign o_load_mdr        = w_load_mdr & i_rst_n;
  assign o_load_data_out   = w_load_data_out & i_rst_n;
  assign o_mem_read        = w_mem_read & i_rst_n;
  assign o_mem_write       = w_mem_write & i_rst_n;
  assign o_trap            = w_trap & i_rst_n;
  assign o_mem_byte_enable = i_rst_n ? w_mbe : 4'b1111;
  assign o_pcmux_sel       = w_pcmux;
  assign o_alumux1_sel     = w_alumux1;
  assign o_alumux2_sel     = w_alumux2;
  assign o_regfilemux_sel  = w_regfilemux;
  assign o_marmux_sel      = w_marmux;
  assign o_cmpmux_sel      = w_cmpmux;
  assign o_jalr            = w_jalr;
  assign o_cmpop           = w_cmpop;
  assign o_aluop           = w_aluop;
  assign o_byte_off        = r_byte_off;
  assign o_trap_cause      = r_trap_cause;

`ifdef RV32I_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_waiting && !i_mem_resp) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_retire       = o_load_pc && (r_state != S_TRAP);
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_rv32i_mc_control.sv
// tb/tb_rv32i_mc_control.sv - directed scoreboard bench for rv32i_mc_control (MEM_TIMEOUT = 4)
module tb_rv32i_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       br_en = 1'b0;
  logic [1:0] addr_lo = 2'b00;
  logic       mem_resp = 1'b0;

  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel, byte_off, trap_cause;
  logic       alumux1_sel, marmux_sel, cmpmux_sel, jalr, mem_read, mem_write, trap;
  logic [2:0] alumux2_sel, cmpop, aluop;
  logic [3:0] regfilemux_sel, mem_byte_enable;
`ifdef RV32I_CTRL_PERF_EN
  logic        retire;
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  rv32i_mc_control #(.TIMEOUT_W(8), .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_br_en(br_en), .i_alu_addr_lo(addr_lo), .i_mem_resp(mem_resp),
    .o_load_pc(load_pc), .o_load_ir(load_ir), .o_load_regfile(load_regfile),
    .o_load_mar(load_mar), .o_load_mdr(load_mdr), .o_load_data_out(load_data_out),
    .o_pcmux_sel(pcmux_sel), .o_alumux1_sel(alumux1_sel), .o_alumux2_sel(alumux2_sel),
    .o_regfilemux_sel(regfilemux_sel), .o_marmux_sel(marmux_sel), .o_cmpmux_sel(cmpmux_sel),
    .o_jalr(jalr), .o_cmpop(cmpop), .o_aluop(aluop), .o_byte_off(byte_off),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_byte_enable(mem_byte_enable),
    .o_trap(trap), .o_trap_cause(trap_cause)
`ifdef RV32I_CTRL_PERF_EN
    , .o_retire(retire), .o_stall_cycles(stall_cycles)
`endif
  );

  // strobe vector order: {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, mem_read, mem_write, trap}
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_F1   = 9'b000100000;
  localparam logic [8:0] S_F2   = 9'b000010100;
  localparam logic [8:0] S_F3   = 9'b010000000;
  localparam logic [8:0] S_EXRF = 9'b101000000;
  localparam logic [8:0] S_PC   = 9'b100000000;
  localparam logic [8:0] S_CST  = 9'b000101000;
  localparam logic [8:0] S_STR1 = 9'b000000010;
  localparam logic [8:0] S_TRAP = 9'b100000001;

  typedef struct {
    string      tag;
    logic [8:0] strb;
  } exp_t;

  exp_t       sb_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] obs_strb;
  logic [3:0] obs_mbe, obs_rfm;
  logic [2:0] obs_aluop, obs_am2;
  logic [1:0] obs_pcmux, obs_cause, obs_boff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    obs_strb  = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, mem_read, mem_write, trap};
    obs_mbe   = mem_byte_enable;
    obs_rfm   = regfilemux_sel;
    obs_aluop = aluop;
    obs_am2   = alumux2_sel;
    obs_pcmux = pcmux_sel;
    obs_cause = trap_cause;
    obs_boff  = byte_off;
  endtask

  // one clock: drive, push expected strobes, compare at the falling edge, advance past the next rising edge
  task automatic cyc(input string tag, input logic [8:0] strb, input logic resp);
    exp_t e;
    mem_resp = resp;
    e.tag  = tag;
    e.strb = strb;
    sb_q.push_back(e);
    @(negedge clk);
    sample();
    e = sb_q.pop_front();
    chk(e.tag, 32'(obs_strb), 32'(e.strb));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input string tag);
    cyc({tag, "_f1"}, S_F1, 1'b0);
    cyc({tag, "_f2"}, S_F2, 1'b1);
    cyc({tag, "_f3"}, S_F3, 1'b0);
    cyc({tag, "_dec"}, S_NONE, 1'b0);
  endtask

  logic [2:0] st_f3[4]  = '{3'b000, 3'b001, 3'b010, 3'b000};
  logic [1:0] st_lo[4]  = '{2'b10, 2'b10, 2'b00, 2'b11};
  logic [3:0] st_mbe[4] = '{4'b0100, 4'b1100, 4'b1111, 4'b1000};
  logic [2:0] ld_f3[3]  = '{3'b100, 3'b101, 3'b010};
  logic [1:0] ld_lo[3]  = '{2'b11, 2'b10, 2'b00};
  logic [3:0] ld_rfm[3] = '{4'd8, 4'd6, 4'd3};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample();
    chk("rst_strobes", 32'(obs_strb), 32'(S_NONE));
    chk("rst_mbe", 32'(obs_mbe), 32'hF);
    chk("rst_cause", 32'(obs_cause), 32'd0);
    chk("rst_boff", 32'(obs_boff), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi, response on the second FETCH2 cycle
    cyc("addi_f1", S_F1, 1'b0);
    cyc("addi_f2a", S_F2, 1'b0);
    cyc("addi_f2b", S_F2, 1'b1);
    cyc("addi_f3", S_F3, 1'b0);
    cyc("addi_dec", S_NONE, 1'b0);
    cyc("addi_imm", S_EXRF, 1'b0);
    chk("addi_aluop", 32'(obs_aluop), 32'd0);
    chk("addi_pcmux", 32'(obs_pcmux), 32'd0);

    // sub via REG
    opcode = 7'b0110011; funct7 = 7'b0100000;
    fetch_dec("sub");
    cyc("sub_reg", S_EXRF, 1'b0);
    chk("sub_aluop", 32'(obs_aluop), 32'd2);
    chk("sub_am2", 32'(obs_am2), 32'd5);
    funct7 = 7'b0000000;

    // taken branch
    opcode = 7'b1100011; br_en = 1'b1;
    fetch_dec("br");
    cyc("br_ex", S_PC, 1'b0);
    chk("br_pcmux", 32'(obs_pcmux), 32'd1);
    br_en = 1'b0;

    // stores: byte lane steering from the registered offset
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      funct3 = st_f3[i];
      fetch_dec("st");
      addr_lo = st_lo[i];
      cyc("st_calc", S_CST, 1'b0);
      addr_lo = 2'b00;
      cyc("st_str1a", S_STR1, 1'b0);
      chk("st_mbe", 32'(obs_mbe), 32'(st_mbe[i]));
      chk("st_boff", 32'(obs_boff), 32'(st_lo[i]));
      cyc("st_str1b", S_STR1, 1'b1);
      cyc("st_str2", S_PC, 1'b0);
    end

    // legal loads and their extraction select
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) begin
      funct3 = ld_f3[i];
      fetch_dec("ld");
      addr_lo = ld_lo[i];
      cyc("ld_calc", S_F1, 1'b0);
      addr_lo = 2'b00;
      cyc("ld_ldr1", S_F2, 1'b1);
      cyc("ld_ldr2", S_EXRF, 1'b0);
      chk("ld_rfm", 32'(obs_rfm), 32'(ld_rfm[i]));
      chk("ld_boff", 32'(obs_boff), 32'(ld_lo[i]));
    end

    // misaligned lw, then misaligned sh
    funct3 = 3'b010;
    fetch_dec("lwmis");
    addr_lo = 2'b01;
    cyc("lwmis_calc", S_NONE, 1'b0);
    cyc("lwmis_trap", S_TRAP, 1'b0);
    chk("lwmis_cause", 32'(obs_cause), 32'd1);
    chk("lwmis_pcmux", 32'(obs_pcmux), 32'd2);
    opcode = 7'b0100011; funct3 = 3'b001;
    fetch_dec("shmis");
    cyc("shmis_calc", S_NONE, 1'b0);
    cyc("shmis_trap", S_TRAP, 1'b0);
    chk("shmis_cause", 32'(obs_cause), 32'd2);
    addr_lo = 2'b00;

    // illegal opcode
    opcode = 7'b0000000; funct3 = 3'b000;
    fetch_dec("ill");
    cyc("ill_trap", S_TRAP, 1'b0);
    chk("ill_cause", 32'(obs_cause), 32'd0);
    chk("ill_pcmux", 32'(obs_pcmux), 32'd2);

    // fetch timeout: four read cycles then trap
    opcode = 7'b0010011;
    cyc("to_f1", S_F1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("to_f2", S_F2, 1'b0);
    cyc("to_trap", S_TRAP, 1'b0);
    chk("to_cause", 32'(obs_cause), 32'd3);

    // response on the fourth cycle wins over expiry
    cyc("late_f1", S_F1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("late_f2", S_F2, 1'b0);
    cyc("late_f2resp", S_F2, 1'b1);
    cyc("late_f3", S_F3, 1'b0);
    cyc("late_dec", S_NONE, 1'b0);
    cyc("late_imm", S_EXRF, 1'b0);

    // reset in the middle of LDR1
    opcode = 7'b0000011; funct3 = 3'b010;
    fetch_dec("rld");
    cyc("rld_calc", S_F1, 1'b0);
    cyc("rld_ldr1", S_F2, 1'b0);
    #2;
    chk("rld_pre_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rld_read_drop", 32'(mem_read), 32'd0);
    chk("rld_mdr_drop", 32'(load_mdr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rld_f1", S_F1, 1'b0);
    cyc("rld_f2", S_F2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
